bin_to_bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm. It processes one input bit per clock instead of unrolling all bits into one combinational cone.
Adds a start/busy/done handshake, overflow saturation and a leading-zero blanking mask. It sits between counter/arithmetic logic and the per-digit seven-segment decoders on the display path.

---
 rtl/bin_to_bcd_seq.sv | 86 ++++++++
 tb/tb_bin_to_bcd_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter with handshake, saturation and blanking
module bin_to_bcd_seq #(
   parameter int BIN_W  = 20,
   parameter int DIGITS = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      binary,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow,
   output logic [DIGITS-1:0]     blank_n
);
   localparam int NW = 4*DIGITS;
   localparam int CW = $clog2(BIN_W+1);
   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
   state_t            state;
   logic [BIN_W-1:0]  sreg;
   logic [NW-1:0]     nib, adj, fin;
   logic              sticky, bad;
   logic [CW-1:0]     cnt;
   logic [DIGITS-1:0] blank;
   // add 3 to every working nibble that is 5 or more ahead of the shift
   always_comb begin
      adj = nib;
      for (int i = 0; i < DIGITS; i++)
         adj[4*i+:4] = (nib[4*i+:4] >= 4'd5) ? nib[4*i+:4] + 4'd3 : nib[4*i+:4];
   end
   // saturate on a lost carry or an illegal digit, then derive leading-zero blanking from the final digits
   always_comb begin
      bad = sticky;
      for (int i = 0; i < DIGITS; i++)
         bad = bad | (nib[4*i+:4] > 4'd9);
      fin = bad ? {DIGITS{4'h9}} : nib;
      blank = '0;
      blank[DIGITS-1] = |fin[NW-1-:4];
      for (int i = DIGITS-2; i >= 0; i--)
         blank[i] = blank[i+1] | (|fin[4*i+:4]);
      blank[0] = 1'b1;
   end
   // control FSM, one-bit-per-clock shift datapath and registered results
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         sreg     <= '0;
         nib      <= '0;
         sticky   <= 1'b0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         bcd      <= '0;
         overflow <= 1'b0;
         blank_n  <= DIGITS'(1);
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               sreg   <= binary;
               nib    <= '0;
               sticky <= 1'b0;
               cnt    <= CW'(BIN_W);
               busy   <= 1'b1;
               state  <= SHIFT;
            end
            SHIFT: begin
               nib    <= {adj[NW-2:0], sreg[BIN_W-1]};
               sreg   <= sreg << 1;
               sticky <= sticky | adj[NW-1];
               cnt    <= cnt - CW'(1);
               state  <= (cnt == CW'(1)) ? FINISH : SHIFT;
            end
            FINISH: begin
               bcd      <= fin;
               overflow <= bad;
               blank_n  <= blank;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed self-checking bench for the sequential binary-to-BCD converter
module tb_bin_to_bcd_seq;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, start8 = 1'b0;
   logic [19:0] binary = '0;
   logic [7:0]  binary8 = '0;
   logic        busy, done, overflow, busy8, done8, overflow8;
   logic [23:0] bcd;
   logic [11:0] bcd8;
   logic [5:0]  blank_n;
   logic [2:0]  blank_n8;
   int checks = 0, errors = 0;
   int lat, bcnt, dcnt;

   always #5 clk = ~clk;

   bin_to_bcd_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .binary(binary), .busy(busy),
      .done(done), .bcd(bcd), .overflow(overflow), .blank_n(blank_n)
   );

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .binary(binary8), .busy(busy8),
      .done(done8), .bcd(bcd8), .overflow(overflow8), .blank_n(blank_n8)
   );

   task automatic convert(input logic [19:0] v, input bit inject, output int l, output int bc, output int dc);
      @(negedge clk); start = 1'b1; binary = v;
      @(posedge clk); #1; start = 1'b0; binary = 20'hABCDE;
      bc = busy ? 1 : 0; dc = 0; l = -1;
      for (int n = 1; n <= 60 && l < 0; n++) begin
         @(posedge clk); #1;
         start = inject && (n == 3 || n == 20);
         if (start) binary = 20'd1;
         bc += busy ? 1 : 0;
         dc += done ? 1 : 0;
         if (done) l = n;
      end
      checks++;
      if (l < 0) begin errors++; $display("FAIL timeout value=%0d no done within 60 cycles", v); end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (bcd !== 24'h0) begin errors++; $display("FAIL reset_bcd got %h want 000000", bcd); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
      checks++; if (blank_n !== 6'b000001) begin errors++; $display("FAIL reset_blank got %b want 000001", blank_n); end
      checks++; if (busy8 !== 1'b0 || bcd8 !== 12'h0 || blank_n8 !== 3'b001) begin errors++; $display("FAIL reset_small got busy=%b bcd=%h blank=%b want 0 000 001", busy8, bcd8, blank_n8); end
      rst_n = 1'b1;
   endtask

   task automatic test_zero;
      convert(20'd0, 1'b0, lat, bcnt, dcnt);
      checks++; if (lat !== 21) begin errors++; $display("FAIL zero_latency got %0d want 21", lat); end
      checks++; if (bcd !== 24'h000000 || overflow !== 1'b0) begin errors++; $display("FAIL zero_bcd got %h ovf=%b want 000000 ovf=0", bcd, overflow); end
      checks++; if (blank_n !== 6'b000001) begin errors++; $display("FAIL zero_blank got %b want 000001", blank_n); end
   endtask

   task automatic test_values;
      convert(20'd999999, 1'b0, lat, bcnt, dcnt);
      checks++; if (bcd !== 24'h999999 || overflow !== 1'b0) begin errors++; $display("FAIL max_bcd got %h ovf=%b want 999999 ovf=0", bcd, overflow); end
      checks++; if (blank_n !== 6'b111111) begin errors++; $display("FAIL max_blank got %b want 111111", blank_n); end
      convert(20'd12345, 1'b0, lat, bcnt, dcnt);
      checks++; if (bcd !== 24'h012345 || overflow !== 1'b0) begin errors++; $display("FAIL v12345_bcd got %h ovf=%b want 012345 ovf=0", bcd, overflow); end
      checks++; if (blank_n !== 6'b011111) begin errors++; $display("FAIL v12345_blank got %b want 011111", blank_n); end
      // result must hold after done until the next conversion
      repeat (5) @(posedge clk);
      #1;
      checks++; if (bcd !== 24'h012345 || done !== 1'b0) begin errors++; $display("FAIL hold got bcd=%h done=%b want 012345 done=0", bcd, done); end
   endtask

   task automatic test_overflow;
      convert(20'd1000000, 1'b0, lat, bcnt, dcnt);
      checks++; if (bcd !== 24'h999999 || overflow !== 1'b1 || blank_n !== 6'b111111) begin errors++; $display("FAIL ovf_1e6 got %h ovf=%b blank=%b want 999999 ovf=1 blank=111111", bcd, overflow, blank_n); end
      convert(20'hFFFFF, 1'b0, lat, bcnt, dcnt);
      checks++; if (bcd !== 24'h999999 || overflow !== 1'b1 || blank_n !== 6'b111111) begin errors++; $display("FAIL ovf_fffff got %h ovf=%b blank=%b want 999999 ovf=1 blank=111111", bcd, overflow, blank_n); end
      convert(20'd7, 1'b0, lat, bcnt, dcnt);
      checks++; if (bcd !== 24'h000007 || overflow !== 1'b0 || blank_n !== 6'b000001) begin errors++; $display("FAIL ovf_clear got %h ovf=%b blank=%b want 000007 ovf=0 blank=000001", bcd, overflow, blank_n); end
   endtask

   task automatic test_back_to_back;
      int n;
      convert(20'd4660, 1'b1, lat, bcnt, dcnt);
      checks++; if (lat !== 21 || dcnt !== 1) begin errors++; $display("FAIL ignore_start got latency=%0d dones=%0d want 21 1", lat, dcnt); end
      checks++; if (bcnt !== 21) begin errors++; $display("FAIL busy_len got %0d want 21", bcnt); end
      checks++; if (bcd !== 24'h004660 || blank_n !== 6'b001111) begin errors++; $display("FAIL v4660 got %h blank=%b want 004660 blank=001111", bcd, blank_n); end
      // done is high now; a start in this cycle must be accepted
      start = 1'b1; binary = 20'd321;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL done_cycle_accept got busy=%b done=%b want 1 0", busy, done); end
      n = 0;
      while (n < 60 && done !== 1'b1) begin
         @(posedge clk); #1;
         n++;
      end
      checks++; if (n !== 21 || bcd !== 24'h000321) begin errors++; $display("FAIL chained got latency=%0d bcd=%h want 21 000321", n, bcd); end
   endtask

   task automatic test_mid_reset;
      int d = 0;
      @(negedge clk); start = 1'b1; binary = 20'd55555;
      @(posedge clk); #1; start = 1'b0;
      repeat (10) @(posedge clk);
      #1; rst_n = 1'b0;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || bcd !== 24'h0 || blank_n !== 6'b000001) begin errors++; $display("FAIL mid_reset got busy=%b done=%b bcd=%h blank=%b want 0 0 000000 000001", busy, done, bcd, blank_n); end
      rst_n = 1'b1;
      repeat (30) begin
         @(posedge clk); #1;
         d += done ? 1 : 0;
      end
      checks++; if (d !== 0) begin errors++; $display("FAIL mid_reset_nodone got %0d dones want 0", d); end
      convert(20'd42, 1'b0, lat, bcnt, dcnt);
      checks++; if (lat !== 21 || bcd !== 24'h000042 || blank_n !== 6'b000011) begin errors++; $display("FAIL after_reset got latency=%0d bcd=%h blank=%b want 21 000042 000011", lat, bcd, blank_n); end
   endtask

   task automatic test_small;
      logic [7:0]  vals [2]  = '{8'd255, 8'd9};
      logic [11:0] exp_b [2] = '{12'h255, 12'h009};
      logic [2:0]  exp_k [2] = '{3'b111, 3'b001};
      int n;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); start8 = 1'b1; binary8 = vals[k];
         @(posedge clk); #1; start8 = 1'b0; binary8 = 8'hA5;
         n = 0;
         while (n < 30 && done8 !== 1'b1) begin
            @(posedge clk); #1;
            n++;
         end
         checks++; if (n !== 9) begin errors++; $display("FAIL small_latency value=%0d got %0d want 9", vals[k], n); end
         checks++; if (bcd8 !== exp_b[k] || overflow8 !== 1'b0 || blank_n8 !== exp_k[k]) begin errors++; $display("FAIL small value=%0d got %h ovf=%b blank=%b want %h ovf=0 blank=%b", vals[k], bcd8, overflow8, blank_n8, exp_b[k], exp_k[k]); end
      end
   endtask

   initial begin
      test_reset;
      test_zero;
      test_values;
      test_overflow;
      test_back_to_back;
      test_mid_reset;
      test_small;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
